// File: rtl/sta_result_reader.sv
// sta_result_reader: captures the STA result bus every SAMPLE_DIV cycles into a
// small FIFO, drains each word MSB-first over a bit-serial valid/ready link and
// keeps a rotate-XOR signature of every accepted capture.
module sta_result_reader #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int SAMPLE_DIV = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        din,
  input  logic                     cap_en,
  input  logic                     ser_ready,
  output logic                     ser_valid,
  output logic                     ser_data,
  output logic                     ser_sof,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [DATA_W-1:0]        signature
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int BW = $clog2(DATA_W);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_level;
  logic [SW-1:0]     r_scnt;
  logic              r_ovf;
  logic [DATA_W-1:0] r_sig;

  state_t            r_state;
  logic [DATA_W-1:0] r_shreg;
  logic [BW-1:0]     r_bitcnt;
  logic              r_valid;
  logic              r_data;
  logic              r_sof;

  logic              w_strobe;
  logic              w_full;
  logic              w_empty;
  logic              w_last;
  logic              w_pop;
  logic              w_push;
  logic [DATA_W-1:0] w_head;

  // A pop happens when the serializer wants a new word: from IDLE, or as the
  // final bit of the current word transfers (back-to-back words, no bubble).
  // A push into a full FIFO is still accepted if a pop frees a slot this edge.
  assign w_strobe = cap_en && (r_scnt == SW'(SAMPLE_DIV - 1));
  assign w_full   = (r_level == (AW+1)'(DEPTH));
  assign w_empty  = (r_level == '0);
  assign w_last   = (r_state == SHIFT) && ser_ready && (r_bitcnt == '0);
  assign w_pop    = !w_empty && ((r_state == IDLE) || w_last);
  assign w_push   = w_strobe && (!w_full || w_pop);
  assign w_head   = r_mem[r_rptr];

  // Sample counter: runs 0..SAMPLE_DIV-1 while capture is enabled
  always_ff @(posedge clk) begin
    if (!reset_n || !cap_en || (r_scnt == SW'(SAMPLE_DIV - 1)))
      r_scnt <= '0;
    else
      r_scnt <= r_scnt + SW'(1);
  end

  // FIFO storage write port (storage itself is not reset; pointers are)
  always_ff @(posedge clk) begin
    if (reset_n && w_push)
      r_mem[r_wptr] <= din;
  end

  // FIFO pointers, level, sticky overflow and signature of accepted captures
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ovf   <= 1'b0;
      r_sig   <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
        r_sig  <= {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ din;
      end else if (w_strobe) begin
        r_ovf <= 1'b1;
      end
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Serializer FSM with registered link outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_valid  <= 1'b0;
      r_data   <= 1'b0;
      r_sof    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_state  <= SHIFT;
            r_shreg  <= w_head;
            r_bitcnt <= BW'(DATA_W - 1);
            r_valid  <= 1'b1;
            r_data   <= w_head[DATA_W-1];
            r_sof    <= 1'b1;
          end
        end
        SHIFT: begin
          if (ser_ready) begin
            if (r_bitcnt == '0) begin
              if (w_pop) begin
                r_shreg  <= w_head;
                r_bitcnt <= BW'(DATA_W - 1);
                r_data   <= w_head[DATA_W-1];
                r_sof    <= 1'b1;
              end else begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_data  <= 1'b0;
                r_sof   <= 1'b0;
              end
            end else begin
              r_shreg  <= {r_shreg[DATA_W-2:0], 1'b0};
              r_bitcnt <= r_bitcnt - BW'(1);
              r_data   <= r_shreg[DATA_W-2];
              r_sof    <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ser_valid  = r_valid;
  assign ser_data   = r_data;
  assign ser_sof    = r_sof;
  assign fifo_level = r_level;
  assign overflow   = r_ovf;
  assign signature  = r_sig;

endmodule
